// File: rtl/base_encode_drain.sv
`default_nettype none
// ============================================================================
// Module      : base_encode_drain
// Description : Serialises a multi-hot request vector into a stream of
//               encoded bit indices, one per output beat, with a per-vector
//               sequence number and a last-beat flag. Drain order is
//               lowest-set-bit first (MSB_FIRST=0) or highest first (=1).
//
// Ports       : clk      - clock, rising edge
//               reset_n  - asynchronous active-low reset
//               i_v/i_r  - input vector valid / ready
//               i_d      - request vector (multi-hot allowed)
//               o_v/o_r  - output beat valid / ready
//               o_d      - encoded index of the bit being emitted
//               o_seq    - position of this beat within its vector
//               o_last   - beat carries the final set bit of the vector
//
// Revision    : 1.0 - initial release
// ============================================================================
module base_encode_drain #(
    parameter int ENC_WIDTH = 3,
    parameter int DEC_WIDTH = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_v,
    output logic                 i_r,
    input  logic [DEC_WIDTH-1:0] i_d,
    output logic                 o_v,
    input  logic                 o_r,
    output logic [ENC_WIDTH-1:0] o_d,
    output logic [ENC_WIDTH-1:0] o_seq,
    output logic                 o_last
);

    localparam logic [ENC_WIDTH-1:0] c_top_idx = ENC_WIDTH'(DEC_WIDTH - 1);

    generate
        if (DEC_WIDTH > (1 << ENC_WIDTH)) begin : g_width_check
            $error("base_encode_drain: DEC_WIDTH exceeds 2**ENC_WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [DEC_WIDTH-1:0] pend_q,  pend_d;
    logic [ENC_WIDTH-1:0] seq_q,   seq_d;

    logic                 w_busy;
    logic [DEC_WIDTH-1:0] w_scan;
    logic [ENC_WIDTH-1:0] w_scan_idx;
    logic [ENC_WIDTH-1:0] w_idx;
    logic                 w_single;
    logic [DEC_WIDTH-1:0] w_clr_mask;
    logic                 w_out_fire;
    logic                 w_in_fire;

    assign w_busy = (state_q == ST_DRAIN);

    // The encoder always searches for the lowest set bit of w_scan; for
    // MSB-first drain the pending vector is bit-reversed before the search
    // and the found position is mapped back afterwards.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            for (genvar i = 0; i < DEC_WIDTH; i++) begin : g_rev
                assign w_scan[i] = pend_q[DEC_WIDTH-1-i];
            end
        end else begin : g_lsb
            assign w_scan = pend_q;
        end
    endgenerate

    // Priority encoder: descending loop, so the lowest set bit wins.
    always_comb begin
        w_scan_idx = '0;
        for (int i = DEC_WIDTH - 1; i >= 0; i--) begin
            if (w_scan[i]) begin
                w_scan_idx = ENC_WIDTH'(i);
            end
        end
    end

    generate
        if (MSB_FIRST != 0) begin : g_idx_msb
            assign w_idx = c_top_idx - w_scan_idx;
        end else begin : g_idx_lsb
            assign w_idx = w_scan_idx;
        end
    endgenerate

    // Exactly one bit left: nonzero and clearing the lowest bit empties it.
    assign w_single   = (pend_q != '0) &&
                        ((pend_q & (pend_q - DEC_WIDTH'(1))) == '0);
    assign w_clr_mask = DEC_WIDTH'(1) << w_idx;

    assign o_v    = w_busy;
    assign o_d    = w_busy ? w_idx : '0;
    assign o_seq  = w_busy ? seq_q : '0;
    assign o_last = w_busy & w_single;

    // o_r feeds i_r combinationally so a new vector can be taken in the
    // same cycle as the last beat of the current one (no bubble).
    assign i_r = ~w_busy | (o_last & o_r);

    assign w_out_fire = w_busy & o_r;
    assign w_in_fire  = i_v & i_r;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        seq_d   = seq_q;

        if (w_out_fire) begin
            pend_d = pend_q & ~w_clr_mask;
            if (w_single) begin
                state_d = ST_IDLE;
                seq_d   = '0;
            end else begin
                seq_d = seq_q + ENC_WIDTH'(1);
            end
        end

        // A new vector overrides whatever the drain step produced; an
        // all-zero vector is consumed without generating any beat.
        if (w_in_fire) begin
            seq_d = '0;
            if (i_d != '0) begin
                pend_d  = i_d;
                state_d = ST_DRAIN;
            end else begin
                pend_d  = '0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            seq_q   <= seq_d;
        end
    end

endmodule
`default_nettype wire
